keep_one_in_n_unzip: RTL and testbench

//  Receive-side inverse of the 8-bit IQ packer. Each 32-bit input word carries four 8-bit

---
 rtl/keep_one_in_n_unzip.sv | 127 ++++++++++++
 tb/tb_keep_one_in_n_unzip.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/keep_one_in_n_unzip.sv
// keep_one_in_n_unzip
//   Receive-side inverse of the 8-bit IQ packer. Each input word carries four
//   8-bit symbols (high nibble I, low nibble Q, each {sign, mag[2:0]}). Every
//   accepted word is expanded into four sc16 IQ samples {I16, Q16}, emitted in
//   the packer's order: bytes [23:16], [31:24], [7:0], [15:8].
//
// Parameters
//   WIDTH     AXI-Stream data width, in and out (only 32 is supported).
//   MID_RISE  Fill for the dropped low bits: 0 -> 9'h000, 1 -> 9'h100.
//
// Ports
//   clk       clock
//   reset     synchronous, active-high reset
//   i_tdata   packed word, four 8-bit symbols
//   i_tlast   last packed word of the packet
//   i_tvalid  input valid
//   i_tready  input ready (only when empty, or on the final beat of a word)
//   o_tdata   expanded sample {I16, Q16}
//   o_tlast   last sample of the packet (beat3 of a word tagged i_tlast)
//   o_tvalid  output valid
//   o_tready  output ready
module keep_one_in_n_unzip #(
   parameter int WIDTH    = 32,
   parameter bit MID_RISE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready
);

   typedef enum logic {
      EMPTY = 1'b0,
      EMIT  = 1'b1
   } state_t;

   localparam logic [8:0] FILL9 = MID_RISE ? 9'h100 : 9'h000;

   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             last_q, last_d;
   logic             last_beat;
   logic [7:0]       sym;

   // Sign-extend the 3-bit magnitude field into the top of a 16-bit sample.
   function automatic logic [15:0] expand(input logic [3:0] n);
      return {{4{n[3]}}, n[2:0], FILL9};
   endfunction

   assign last_beat = (cnt_q == 2'd3);

   // NOTE: every signal assigned in this always_comb gets a default first, so
   // no path through the case can leave a value unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      last_d   = last_q;
      i_tready = (state_q == EMPTY) | (o_tready & last_beat);

      unique case (state_q)
         EMPTY: begin
            if (i_tvalid) begin
               state_d = EMIT;
               cnt_d   = 2'd0;
               word_d  = i_tdata;
               last_d  = i_tlast;
            end
         end
         EMIT: begin
            if (o_tready) begin
               if (!last_beat) begin
                  cnt_d = cnt_q + 2'd1;
               end else if (i_tvalid) begin
                  // Reload on the final beat so a continuous stream has no bubble.
                  cnt_d  = 2'd0;
                  word_d = i_tdata;
                  last_d = i_tlast;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         cnt_q   <= 2'd0;
         word_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      sym = 8'h00;
      unique case (cnt_q)
         2'd0: sym = word_q[23:16];
         2'd1: sym = word_q[31:24];
         2'd2: sym = word_q[7:0];
         2'd3: sym = word_q[15:8];
         default: sym = 8'h00;
      endcase
   end

   assign o_tvalid = (state_q == EMIT);
   assign o_tlast  = o_tvalid & last_q & last_beat;
   // Gate with valid so the idle output is zero even when FILL9 is non-zero.
   assign o_tdata  = o_tvalid ? {expand(sym[7:4]), expand(sym[3:0])} : '0;

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// Self-checking bench for keep_one_in_n_unzip. Two instances (MID_RISE 0 and 1)
// share one stimulus stream; a queue-based model of the expected output beats
// is checked every cycle, plus directed literal expectations.
module tb_keep_one_in_n_unzip;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        o_tready;
   logic        i_tready0, i_tready1;
   logic [31:0] o_tdata0, o_tdata1;
   logic        o_tlast0, o_tlast1;
   logic        o_tvalid0, o_tvalid1;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   always #5 clk = ~clk;

   keep_one_in_n_unzip #(.WIDTH(32), .MID_RISE(1'b0)) u_dut0 (
      .clk(clk), .reset(reset),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready0),
      .o_tdata(o_tdata0), .o_tlast(o_tlast0), .o_tvalid(o_tvalid0), .o_tready(o_tready)
   );

   keep_one_in_n_unzip #(.WIDTH(32), .MID_RISE(1'b1)) u_dut1 (
      .clk(clk), .reset(reset),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready1),
      .o_tdata(o_tdata1), .o_tlast(o_tlast1), .o_tvalid(o_tvalid1), .o_tready(o_tready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a nibble {s, m} is the signed value (s ? m-8 : m) in units of 512,
   // plus the mid-rise offset of 256.
   function automatic logic [15:0] exp16(input logic [3:0] n, input bit mr);
      int v;
      v = ((n[3] ? -8 : 0) + int'(n[2:0])) * 512 + (mr ? 256 : 0);
      return v[15:0];
   endfunction

   function automatic logic [31:0] exp_beat(input logic [31:0] w, input int k, input bit mr);
      int         byte_idx [4];
      logic [7:0] s;
      byte_idx = '{2, 3, 0, 1};
      s = w[byte_idx[k]*8 +: 8];
      return {exp16(s[7:4], mr), exp16(s[3:0], mr)};
   endfunction

   typedef struct packed {
      logic [31:0] d0;
      logic [31:0] d1;
      logic        last;
   } beat_t;

   beat_t       q[$];
   bit          p_stall = 1'b0;
   logic [31:0] p_data0, p_data1;

   // Every-cycle compare against the beat queue, then advance the model to the
   // values that the coming rising edge will sample.
   always @(negedge clk) begin
      if (mon_en) begin
         bit    exp_rdy;
         beat_t b;
         exp_rdy = (q.size() == 0) || (q.size() == 1 && o_tready);
         check("o_tvalid0", o_tvalid0, q.size() != 0);
         check("o_tvalid1", o_tvalid1, q.size() != 0);
         check("i_tready0", i_tready0, exp_rdy);
         check("i_tready1", i_tready1, exp_rdy);
         if (q.size() != 0) begin
            check("o_tdata0", o_tdata0, q[0].d0);
            check("o_tdata1", o_tdata1, q[0].d1);
            check("o_tlast0", o_tlast0, q[0].last);
            check("o_tlast1", o_tlast1, q[0].last);
         end
         if (p_stall) begin
            check("stall_stable0", o_tdata0, p_data0);
            check("stall_stable1", o_tdata1, p_data1);
         end
         p_stall = o_tvalid0 && !o_tready && !reset;
         p_data0 = o_tdata0;
         p_data1 = o_tdata1;
         if (reset) begin
            q.delete();
         end else begin
            if (q.size() != 0 && o_tready) void'(q.pop_front());
            if (i_tvalid && exp_rdy) begin
               for (int k = 0; k < 4; k++) begin
                  b.d0   = exp_beat(i_tdata, k, 1'b0);
                  b.d1   = exp_beat(i_tdata, k, 1'b1);
                  b.last = i_tlast && (k == 3);
                  q.push_back(b);
               end
            end
         end
      end
   end

   task automatic drain();
      int n = 0;
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      @(negedge clk);
      while (o_tvalid0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("drain_timeout", 32'd1, 32'd0);
   endtask

   logic [31:0] t1_exp0 [4];
   logic [31:0] t1_exp1 [4];

   initial begin
      int words;
      int cyc;
      bit acc;

      t1_exp0 = '{32'hF6000200, 32'hF200F400, 32'h0E00FE00, 32'h0600F800};
      t1_exp1 = '{32'hF7000300, 32'hF300F500, 32'h0F00FF00, 32'h0700F900};

      reset    = 1'b1;
      i_tdata  = '0;
      i_tlast  = 1'b0;
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_o_tvalid", o_tvalid0, 32'd0);
      check("rst_o_tlast", o_tlast0, 32'd0);
      check("rst_o_tdata0", o_tdata0, 32'd0);
      check("rst_o_tdata1", o_tdata1, 32'd0);
      check("rst_i_tready", i_tready0, 32'd1);
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Single word, both fill modes, beat order and one-cycle latency.
      @(posedge clk); #1;
      i_tdata  = 32'h9AB13C7F;
      i_tlast  = 1'b0;
      i_tvalid = 1'b1;
      @(posedge clk); #1;
      i_tvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("t1_beat%0d", k), o_tdata0, t1_exp0[k]);
         check($sformatf("t2_beat%0d", k), o_tdata1, t1_exp1[k]);
      end
      drain();

      // Back-to-back words: no gap, ready only on beat3, tlast only on beat3 of word A.
      @(posedge clk); #1;
      i_tdata  = 32'h9AB13C7F;
      i_tlast  = 1'b1;
      i_tvalid = 1'b1;
      @(posedge clk); #1;
      i_tdata  = 32'h12345678;
      i_tlast  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check($sformatf("b2b_valid%0d", k), o_tvalid0, 32'd1);
         check($sformatf("b2b_ready%0d", k), i_tready0, (k % 4 == 3));
         check($sformatf("b2b_last%0d", k), o_tlast0, (k == 3));
         check($sformatf("b2b_data%0d", k), o_tdata0,
               exp_beat(k < 4 ? 32'h9AB13C7F : 32'h12345678, k % 4, 1'b0));
      end
      @(posedge clk); #1;
      drain();

      // Reset in the middle of a word.
      @(posedge clk); #1;
      i_tdata  = 32'h13572468;
      i_tlast  = 1'b1;
      i_tvalid = 1'b1;
      @(posedge clk); #1;
      i_tvalid = 1'b0;
      @(negedge clk);
      check("rst_mid_beat0", o_tdata0, exp_beat(32'h13572468, 0, 1'b0));
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_beat1", o_tdata0, exp_beat(32'h13572468, 1, 1'b0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_valid", o_tvalid0, 32'd0);
      check("rst_mid_ready", i_tready0, 32'd1);
      @(posedge clk); #1;
      i_tdata  = 32'h0F0F0F0F;
      i_tlast  = 1'b0;
      i_tvalid = 1'b1;
      @(posedge clk); #1;
      i_tvalid = 1'b0;
      @(negedge clk);
      check("rst_restart_beat0", o_tdata0, 32'h0000FE00);
      drain();

      // Random traffic with random backpressure.
      words = 0;
      cyc   = 0;
      while (words < 1000 && cyc < 20000) begin
         @(negedge clk);
         acc = i_tvalid && i_tready0;
         @(posedge clk); #1;
         cyc++;
         if (acc) words++;
         if (!i_tvalid || acc) begin
            i_tvalid = ($urandom_range(0, 3) != 0);
            i_tdata  = $urandom;
            i_tlast  = $urandom_range(0, 1);
         end
         o_tready = $urandom_range(0, 1);
      end
      check("random_words", words, 32'd1000);
      drain();
      check("model_empty", q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
